// File: rtl/iic_slave_regs_if.sv
// Register-activity side of iic_slave_regs: write/read strobes and the bus-busy flag.
// The slave modport is the DUT side; the master modport is on-chip consumer logic.
interface iic_slave_regs_if #(
  parameter int REG_AW = 4
);
  logic              reg_wr_stb;
  logic [REG_AW-1:0] reg_wr_addr;
  logic [7:0]        reg_wr_data;
  logic              reg_rd_stb;
  logic [REG_AW-1:0] reg_rd_addr;
  logic              busy;

  modport slave (
    output reg_wr_stb, reg_wr_addr, reg_wr_data,
    output reg_rd_stb, reg_rd_addr, busy
  );

  modport master (
    input reg_wr_stb, reg_wr_addr, reg_wr_data,
    input reg_rd_stb, reg_rd_addr, busy
  );
endinterface

// File: rtl/iic_slave_regs.sv
// I2C slave with an internal 2**REG_AW x 8 register bank and an auto-incrementing pointer.
// Bus-initiated writes and byte loads for transmission are reported as one-cycle strobes.
module iic_slave_regs #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         REG_AW      = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  inout  wire             iic_scl,
  inout  wire             iic_sda,
  iic_slave_regs_if.slave regs
);

  localparam int DEPTH = 2 ** REG_AW;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    ACK_DEV,
    REGPTR,
    ACK_PTR,
    WR_DATA,
    ACK_WR,
    RD_DATA,
    MACK
  } state_e;

  // ---------------------------------------------------------------------------
  // Pin synchronisers and edge / condition detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Sync chains reset to the idle-high bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], iic_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], iic_sda};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,     state_d;
  logic [2:0]        bit_cnt_q,   bit_cnt_d;
  logic [7:0]        shift_q,     shift_d;
  logic [REG_AW-1:0] ptr_q,       ptr_d;
  logic              rw_q,        rw_d;
  logic              ack_phase_q, ack_phase_d;
  logic              sda_oe_q,    sda_oe_d;
  logic              busy_q,      busy_d;

  logic [7:0]        bank_q [DEPTH];
  logic [REG_AW-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [REG_AW-1:0] rd_addr_q;

  logic              wr_commit;
  logic              rd_load;
  logic [REG_AW-1:0] rd_load_addr;

  logic [7:0]        rx_byte;
  logic              byte_done;
  logic              ptr_ok;
  logic [REG_AW-1:0] ptr_inc;
  logic [7:0]        cur_byte;
  logic [7:0]        next_byte;

  assign rx_byte   = {shift_q[6:0], sda_s};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd7);
  assign ptr_ok    = (rx_byte >> REG_AW) == 8'h00;
  assign ptr_inc   = ptr_q + REG_AW'(1);
  assign cur_byte  = bank_q[ptr_q];
  assign next_byte = bank_q[ptr_inc];

  // NOTE: every _d and strobe gets its default first, so no path through the
  // case leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ptr_d        = ptr_q;
    rw_d         = rw_q;
    ack_phase_d  = ack_phase_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    wr_commit    = 1'b0;
    rd_load      = 1'b0;
    rd_load_addr = ptr_q;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = DEVADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end

        DEVADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_done) begin
            if (rx_byte[7:1] == DEV_ADDR) begin
              state_d     = ACK_DEV;
              rw_d        = rx_byte[0];
              busy_d      = 1'b1;
              ack_phase_d = 1'b0;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end

        REGPTR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_done) begin
            if (ptr_ok) begin
              ptr_d       = rx_byte[REG_AW-1:0];
              state_d     = ACK_PTR;
              ack_phase_d = 1'b0;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_done) begin
            wr_commit   = 1'b1;
            state_d     = ACK_WR;
            ack_phase_d = 1'b0;
          end
        end

        // First falling edge starts the ack bit, the second one ends it.
        ACK_DEV, ACK_PTR, ACK_WR: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ACK_DEV) begin
                if (rw_q) begin
                  rd_load  = 1'b1;
                  shift_d  = cur_byte;
                  sda_oe_d = ~cur_byte[7];
                  state_d  = RD_DATA;
                end else begin
                  state_d = REGPTR;
                end
              end else if (state_q == ACK_PTR) begin
                state_d = WR_DATA;
              end else begin
                ptr_d   = ptr_inc;
                state_d = WR_DATA;
              end
            end
          end
        end

        RD_DATA: begin
          if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d     = MACK;
              ack_phase_d = 1'b0;
            end
          end
        end

        MACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = 1'b0;
              ack_phase_d = 1'b1;
            end else begin
              ptr_d        = ptr_inc;
              rd_load      = 1'b1;
              rd_load_addr = ptr_inc;
              shift_d      = next_byte;
              sda_oe_d     = ~next_byte[7];
              bit_cnt_d    = '0;
              state_d      = RD_DATA;
            end
          end else if (scl_rise && ack_phase_q && sda_s) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // NOTE: non-blocking assignments make every flop capture pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      ack_phase_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_phase_q <= ack_phase_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: the bank is plain flops, so it can be cleared by reset; a RAM macro
  // could not, and would need a separate clear sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= 8'h00;
      end
    end else if (wr_commit) begin
      bank_q[ptr_q] <= rx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      if (wr_commit) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= rx_byte;
      end
      if (rd_load) begin
        rd_addr_q <= rd_load_addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: strobe cycles present the live values, other cycles the held ones
  // ---------------------------------------------------------------------------
  assign regs.reg_wr_stb  = wr_commit;
  assign regs.reg_wr_addr = wr_commit ? ptr_q : wr_addr_q;
  assign regs.reg_wr_data = wr_commit ? rx_byte : wr_data_q;
  assign regs.reg_rd_stb  = rd_load;
  assign regs.reg_rd_addr = rd_load ? rd_load_addr : rd_addr_q;
  assign regs.busy        = busy_q;

  // Open drain: SDA is only ever pulled low or released; SCL is never driven.
  assign iic_sda = sda_oe_q ? 1'b0 : 1'bz;
  assign iic_scl = 1'bz;

endmodule

// File: tb/tb_iic_slave_regs.sv
// Self-checking bench for iic_slave_regs: bit-banged I2C master, register-bank model,
// and a strobe scoreboard drained by an independent monitor process.
module tb_iic_slave_regs;

  localparam int REG_AW = 4;
  localparam int DEPTH  = 16;
  localparam int QTR    = 6;   // clk cycles per quarter SCL period (SCL = clk/24)

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  wire  iic_scl;
  wire  iic_sda;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic              is_rd;
    logic [REG_AW-1:0] addr;
    logic [7:0]        data;
  } stb_t;

  stb_t       exp_q[$];
  stb_t       mon_act;
  logic       prev_stb = 1'b0;
  logic [7:0] model_bank [DEPTH];
  int         model_ptr = 0;
  logic [7:0] tx_bytes[$];

  always #5 clk = ~clk;

  pullup (iic_scl);
  pullup (iic_sda);
  assign iic_scl = m_scl ? 1'bz : 1'b0;
  assign iic_sda = m_sda ? 1'bz : 1'b0;

  iic_slave_regs_if #(.REG_AW(REG_AW)) regs_if ();

  iic_slave_regs #(
    .DEV_ADDR   (7'h50),
    .REG_AW     (REG_AW),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iic_scl(iic_scl),
    .iic_sda(iic_sda),
    .regs   (regs_if.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe monitor: pops one expectation per strobe cycle.
  always @(negedge clk) begin
    if (rst_n && (regs_if.reg_wr_stb || regs_if.reg_rd_stb)) begin
      mon_act = regs_if.reg_rd_stb ? {1'b1, regs_if.reg_rd_addr, 8'h00}
                                   : {1'b0, regs_if.reg_wr_addr, regs_if.reg_wr_data};
      check("stb_width", 32'(prev_stb), 32'd0);
      if (exp_q.size() == 0) check("stb_queue_nonempty", exp_q.size(), 1);
      else                   check("stb", 32'(mon_act), 32'(exp_q.pop_front()));
      prev_stb = 1'b1;
    end else begin
      prev_stb = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Bit-level master
  // ---------------------------------------------------------------------------
  task automatic q_wait();
    repeat (QTR) @(negedge clk);
  endtask

  function automatic logic bus_sda();
    return (iic_sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b;
    q_wait();
    m_scl = 1'b1;
    q_wait();
    s = bus_sda();
    q_wait();
    m_scl = 1'b0;
    q_wait();
  endtask

  task automatic i2c_start();
    if (!m_scl) begin
      m_sda = 1'b1;
      q_wait();
      m_scl = 1'b1;
      q_wait();
    end
    m_sda = 1'b0;
    q_wait();
    m_scl = 1'b0;
    q_wait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    q_wait();
    m_scl = 1'b1;
    q_wait();
    m_sda = 1'b1;
    q_wait();
    q_wait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d, output logic ack_s);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, ack_s);
  endtask

  // ---------------------------------------------------------------------------
  // Transactions, expectations derived from the register-bank model
  // ---------------------------------------------------------------------------
  task automatic do_write(input logic [7:0] ptr_byte, input bit with_stop);
    logic ack;
    i2c_start();
    write_byte(8'hA0, ack);
    check("dev_ack_w", 32'(ack), 32'd0);
    check("busy_addressed", 32'(regs_if.busy), 32'd1);
    write_byte(ptr_byte, ack);
    if (ptr_byte < 8'(DEPTH)) begin
      check("ptr_ack", 32'(ack), 32'd0);
      model_ptr = int'(ptr_byte);
      foreach (tx_bytes[i]) begin
        exp_q.push_back('{1'b0, REG_AW'(model_ptr), tx_bytes[i]});
        write_byte(tx_bytes[i], ack);
        check("data_ack", 32'(ack), 32'd0);
        model_bank[model_ptr] = tx_bytes[i];
        model_ptr = (model_ptr + 1) % DEPTH;
      end
    end else begin
      check("ptr_nack", 32'(ack), 32'd1);
      check("busy_after_ptr_nack", 32'(regs_if.busy), 32'd0);
      foreach (tx_bytes[i]) begin
        write_byte(tx_bytes[i], ack);
        check("ignored_data_nack", 32'(ack), 32'd1);
      end
    end
    if (with_stop) begin
      i2c_stop();
      check("busy_after_stop_w", 32'(regs_if.busy), 32'd0);
    end
  endtask

  task automatic do_read(input int n);
    logic       ack;
    logic       s;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b1, REG_AW'((model_ptr + i) % DEPTH), 8'h00});
    end
    i2c_start();
    write_byte(8'hA1, ack);
    check("dev_ack_r", 32'(ack), 32'd0);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d, s);
      check("rd_data", 32'(d), 32'(model_bank[model_ptr]));
      if (i != n - 1) model_ptr = (model_ptr + 1) % DEPTH;
    end
    check("sda_released_at_nack", 32'(s), 32'd1);
    i2c_stop();
    check("busy_after_stop_r", 32'(regs_if.busy), 32'd0);
  endtask

  task automatic fill_random(input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic       ack;
    logic [7:0] addr_byte;
    logic       s;

    foreach (model_bank[i]) model_bank[i] = 8'h00;

    repeat (4) @(negedge clk);
    check("rst_sda_released", 32'(bus_sda()), 32'd1);
    check("rst_busy", 32'(regs_if.busy), 32'd0);
    check("rst_wr_stb", 32'(regs_if.reg_wr_stb), 32'd0);
    check("rst_rd_stb", 32'(regs_if.reg_rd_stb), 32'd0);
    check("rst_wr_addr", 32'(regs_if.reg_wr_addr), 32'd0);
    check("rst_wr_data", 32'(regs_if.reg_wr_data), 32'd0);
    check("rst_rd_addr", 32'(regs_if.reg_rd_addr), 32'd0);
    rst_n = 1'b1;
    q_wait();

    // Basic write at ptr 3, then read three bytes from the auto-incremented pointer.
    tx_bytes = '{8'h11, 8'h22};
    do_write(8'h03, 1'b1);
    check("wr_addr_held", 32'(regs_if.reg_wr_addr), 32'd4);
    check("wr_data_held", 32'(regs_if.reg_wr_data), 32'h22);
    do_read(3);
    check("rd_addr_held", 32'(regs_if.reg_rd_addr), 32'd7);

    // Pointer wrap on write, then on read via repeated START.
    tx_bytes = '{8'hAA, 8'hBB};
    do_write(8'h0F, 1'b1);
    tx_bytes.delete();
    do_write(8'h0F, 1'b0);
    do_read(2);

    // Foreign device address: no ack, not busy.
    i2c_start();
    write_byte(8'hA2, ack);
    check("foreign_addr_nack", 32'(ack), 32'd1);
    check("foreign_busy", 32'(regs_if.busy), 32'd0);
    i2c_stop();

    // Out-of-range pointer: NACK, following data ignored.
    tx_bytes = '{8'h77};
    do_write(8'h10, 1'b1);

    // Repeated START read of bank[2].
    tx_bytes = '{8'h5A};
    do_write(8'h02, 1'b1);
    tx_bytes.delete();
    do_write(8'h02, 1'b0);
    do_read(1);

    // Reset asserted while the slave drives the address ACK.
    i2c_start();
    addr_byte = 8'hA0;
    for (int i = 7; i >= 0; i--) clk_bit(addr_byte[i], s);
    m_sda = 1'b1;
    q_wait();
    m_scl = 1'b1;
    q_wait();
    check("ack_driven_before_reset", 32'(bus_sda()), 32'd0);
    rst_n = 1'b0;
    #1;
    check("reset_releases_sda", 32'(bus_sda()), 32'd1);
    check("reset_busy", 32'(regs_if.busy), 32'd0);
    check("reset_wr_data", 32'(regs_if.reg_wr_data), 32'd0);
    check("reset_rd_addr", 32'(regs_if.reg_rd_addr), 32'd0);
    foreach (model_bank[i]) model_bank[i] = 8'h00;
    model_ptr = 0;
    q_wait();
    m_scl = 1'b0;
    q_wait();
    rst_n = 1'b1;
    q_wait();
    i2c_stop();
    do_read(2);
    fill_random(3);
    do_write(8'h07, 1'b1);
    tx_bytes.delete();
    do_write(8'h07, 1'b0);
    do_read(3);

    // Randomised transactions against the model.
    for (int it = 0; it < 12; it++) begin
      int         kind;
      logic [7:0] ptr_byte;
      kind     = int'($urandom_range(0, 2));
      ptr_byte = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255))
                                             : 8'($urandom_range(0, 15));
      case (kind)
        0: begin
          fill_random(int'($urandom_range(1, 4)));
          do_write(ptr_byte, 1'b1);
        end
        1: do_read(int'($urandom_range(1, 4)));
        default: begin
          tx_bytes.delete();
          do_write(ptr_byte, 1'b0);
          do_read(int'($urandom_range(1, 4)));
        end
      endcase
    end

    q_wait();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_slave_regs.md
# iic_slave_regs

I2C slave with a built-in 8-bit register bank. It is the parametrised successor of the basic I2C slave, adding a configurable device address, a configurable bank depth, an auto-incrementing register pointer, and a local write/read strobe interface. It sits on the board-facing I2C pins and exposes bus-initiated register activity to on-chip logic. Standard-mode and fast-mode only: the system clock must be at least 20x SCL. The block never stretches the clock.

## Interface
Parameters:
- DEV_ADDR, 7'h50, 7-bit device address the block responds to.
- REG_AW, 4, register pointer width; bank depth is 2**REG_AW bytes.
- SYNC_STAGES, 2, flip-flop synchroniser depth on SCL and SDA; minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- iic_scl  inout  1  I2C clock; the block only samples it and always drives Z.
- iic_sda  inout  1  I2C data, open-drain; the block drives 1'b0 or Z, never 1.
- reg_wr_stb  output  1  one-cycle pulse when a bus write commits a byte.
- reg_wr_addr  output  REG_AW  bank address of the committed byte.
- reg_wr_data  output  8  committed byte.
- reg_rd_stb  output  1  one-cycle pulse when a byte is loaded for transmission.
- reg_rd_addr  output  REG_AW  bank address of the loaded byte.
- busy  output  1  high from an addressed START until the next STOP, or until a NACK returns the FSM to IDLE.

## Operation
- SCL and SDA pass through SYNC_STAGES flops. Edges are detected on the synchronised versions.
- START: synchronised SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognised in every state.
  - START always resets the bit counter and enters DEVADDR, including a repeated START.
  - STOP always enters IDLE.
- Bits are sampled on the SCL rising edge, MSB first. SDA output changes only on the SCL falling edge.
- States:
  - IDLE: wait for START.
  - DEVADDR: shift 8 bits (address plus R/W).
    - Match: go to ACK_DEV.
    - Mismatch: go to IDLE without acking and ignore the bus until the next START.
  - ACK_DEV: drive SDA low for one SCL period. Then go to REGPTR if W=0, or RD_DATA if R=1. A read starts from the current pointer.
  - REGPTR: shift 8 bits.
    - If bits [7:REG_AW] are nonzero: NACK and go to IDLE.
    - Otherwise load the pointer and go to ACK_PTR.
  - ACK_PTR: ack, then go to WR_DATA.
  - WR_DATA: shift 8 bits. Write the byte into bank[ptr], pulse reg_wr_stb with the addr/data, then go to ACK_WR.
  - ACK_WR: ack, increment the pointer, then go to WR_DATA.
  - RD_DATA: on entry, load bank[ptr] into the shift register, pulse reg_rd_stb, then shift 8 bits out. Go to MACK.
  - MACK: sample the master ack bit.
    - 0: increment the pointer and go to RD_DATA.
    - 1 (NACK): release SDA and go to IDLE.
- Pointer arithmetic is modulo 2**REG_AW: after address 2**REG_AW-1 the pointer wraps to 0. The pointer persists across transactions; it is cleared only by reset.
- The bank is internal flops and is writable only from I2C.

## Timing
- Reset values:
  - All bank bytes, the pointer, and the shift registers: 0.
  - State: IDLE.
  - iic_sda: Z. iic_scl: Z.
  - reg_wr_stb, reg_rd_stb, busy: 0.
  - reg_wr_addr, reg_wr_data, reg_rd_addr: 0.
- Reset asserted mid-transfer releases SDA immediately (asynchronous). After release, the block ignores the bus until a fresh START.
- Input latency: SYNC_STAGES+1 clk from pin to edge detect.
- SDA drive/release occurs within 1 clk of the detected SCL falling edge. This keeps it well inside tHD;DAT.
- reg_wr_stb: exactly 1 clk, on the cycle of the 8th data-bit rising edge detect. Address and data are stable in that cycle and held until the next strobe.
- reg_rd_stb: exactly 1 clk, on the falling edge that ends ACK_DEV or MACK.
- A START and STOP cannot coincide. A STOP inside a byte discards the partial byte: no strobe, no write.

## Test plan
- Write 0xA0 (0x50,W), ptr 0x03, data 0x11 0x22, STOP -> all ACKs low. reg_wr_stb pulses twice with (3,0x11) then (4,0x22). Bank[3]=0x11, bank[4]=0x22. busy low after STOP.
- Following read 0xA1, 3 bytes, master ACK, ACK, NACK -> SDA returns 0x33-region contents bank[5],bank[6],bank[7] (0x00 after reset). reg_rd_stb pulses 3x with addr 5,6,7. SDA released after NACK.
- Write ptr 0x0F, data 0xAA 0xBB -> bank[15]=0xAA, bank[0]=0xBB (wrap).
- Address 0xA2 -> no ACK: SDA Z during the 9th clock, no strobes, busy stays 0. Ptr byte 0x10 with REG_AW=4 -> NACK, FSM in IDLE.
- Write ptr 0x02, then repeated START with 0xA1, read 1 byte -> returns bank[2] without an intervening STOP.
- Assert rst_n low during the ACK bit -> SDA Z within the same cycle. All outputs at their reset values. The next full transaction succeeds.
